// File: rtl/mdio_phy_mgr.sv
// mdio_phy_mgr: sequences the MDIO master driver. Runs a fixed PHY init
// write table after reset, then arbitrates the driver between a host
// register port and a periodic BMSR link poller (host has priority).
// Optional feature macro: MDIO_PHY_MGR_LINK_POLL_EN enables the link poller;
// without it link_up is tied low and only INIT and HOST own the master.
module mdio_phy_mgr #(
   parameter logic [4:0] PHY_ADDR    = 5'd1,
   parameter int         RST_WAIT    = 1000,
   parameter int         POLL_PERIOD = 50000,
   parameter int         TIMEOUT     = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        mdio_start,
   output logic [1:0]  mdio_opcode,
   output logic [4:0]  mdio_phy_addr,
   output logic [4:0]  mdio_reg_addr,
   output logic [15:0] mdio_wdata,
   input  logic        mdio_ready,
   input  logic [15:0] mdio_rdata,
   input  logic        mdio_rdata_en,
   input  logic        host_req,
   input  logic        host_wr,
   input  logic [4:0]  host_reg,
   input  logic [15:0] host_wdata,
   output logic        host_ack,
   output logic [15:0] host_rdata,
   output logic        init_done,
   output logic        link_up,
   output logic        err
);

   typedef enum logic [2:0] {WAIT_RST, ARB, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH} state_t;
   typedef enum logic [1:0] {OWN_INIT, OWN_HOST, OWN_POLL} owner_t;

   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [4:0] BMSR  = 5'h01;
   localparam int RW = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t         state;
   owner_t         owner;
   logic [RW-1:0]  rst_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic [1:0]     init_idx;
   logic [15:0]    cap;
   logic           got_rd;
   logic           txn_err;
   logic           tmo_hit;

   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

   // init table entry: {reg, data}; all entries are writes
   function automatic logic [20:0] init_entry(input logic [1:0] idx);
      case (idx)
         2'd0:    return {5'h00, 16'h1140};
         2'd1:    return {5'h04, 16'h01E1};
         default: return {5'h00, 16'h1340};
      endcase
   endfunction

`ifdef MDIO_PHY_MGR_LINK_POLL_EN
   localparam int PW = $clog2(POLL_PERIOD + 1);
   logic [PW-1:0] poll_cnt;
   logic          poll_due;
   logic          link_q;

   assign poll_due = (poll_cnt == PW'(POLL_PERIOD));
   assign link_up  = link_q;

   // poll timer: idle during init, saturates at the period, restarts when a poll retires
   always_ff @(posedge clk) begin
      if (!reset_n)
         poll_cnt <= '0;
      else if (state == FINISH && owner == OWN_POLL)
         poll_cnt <= '0;
      else if (init_done && !poll_due)
         poll_cnt <= poll_cnt + 1'b1;
   end
`else
   logic unused_poll_cfg;
   assign unused_poll_cfg = ^32'(POLL_PERIOD);
   assign link_up = 1'b0;
`endif

   // transaction sequencer: arbitration, driver handshake, timeout and retirement
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= WAIT_RST;
         owner         <= OWN_INIT;
         rst_cnt       <= '0;
         tmo_cnt       <= '0;
         init_idx      <= 2'd0;
         cap           <= '0;
         got_rd        <= 1'b0;
         txn_err       <= 1'b0;
         mdio_start    <= 1'b0;
         mdio_opcode   <= 2'b00;
         mdio_phy_addr <= 5'd0;
         mdio_reg_addr <= 5'd0;
         mdio_wdata    <= 16'h0;
         host_ack      <= 1'b0;
         host_rdata    <= 16'h0;
         init_done     <= 1'b0;
         err           <= 1'b0;
`ifdef MDIO_PHY_MGR_LINK_POLL_EN
         link_q        <= 1'b0;
`endif
      end else begin
         mdio_start <= 1'b0;
         host_ack   <= 1'b0;
         case (state)
            WAIT_RST: begin
               if (rst_cnt == RW'(RST_WAIT - 1)) state <= ARB;
               else rst_cnt <= rst_cnt + 1'b1;
            end
            ARB: begin
               if (!init_done) begin
                  owner <= OWN_INIT;
                  state <= ISSUE;
               end else if (host_req) begin
                  owner <= OWN_HOST;
                  state <= ISSUE;
               end
`ifdef MDIO_PHY_MGR_LINK_POLL_EN
               else if (poll_due) begin
                  owner <= OWN_POLL;
                  state <= ISSUE;
               end
`endif
            end
            ISSUE: begin
               mdio_start    <= 1'b1;
               mdio_phy_addr <= PHY_ADDR;
               tmo_cnt       <= '0;
               got_rd        <= 1'b0;
               txn_err       <= 1'b0;
               state         <= WAIT_BUSY;
               case (owner)
                  OWN_INIT: begin
                     mdio_opcode                 <= OP_WR;
                     {mdio_reg_addr, mdio_wdata} <= init_entry(init_idx);
                  end
                  OWN_HOST: begin
                     // host fields are captured here only; later changes are ignored
                     mdio_opcode   <= host_wr ? OP_WR : OP_RD;
                     mdio_reg_addr <= host_reg;
                     mdio_wdata    <= host_wr ? host_wdata : 16'h0;
                  end
                  default: begin
                     mdio_opcode   <= OP_RD;
                     mdio_reg_addr <= BMSR;
                     mdio_wdata    <= 16'h0;
                  end
               endcase
            end
            WAIT_BUSY: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_hit) begin
                  err     <= 1'b1;
                  txn_err <= 1'b1;
                  state   <= FINISH;
               end else if (!mdio_ready) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (mdio_rdata_en) begin
                  cap    <= mdio_rdata;
                  got_rd <= 1'b1;
               end
               if (tmo_hit) begin
                  err     <= 1'b1;
                  txn_err <= 1'b1;
                  state   <= FINISH;
               end else if (mdio_ready) begin
                  // a read that completes with no data strobe is a protocol error
                  if (mdio_opcode == OP_RD && !got_rd && !mdio_rdata_en) begin
                     err     <= 1'b1;
                     txn_err <= 1'b1;
                  end
                  state <= FINISH;
               end
            end
            FINISH: begin
               state <= ARB;
               case (owner)
                  OWN_INIT: begin
                     // failed entries still advance so init can never stall
                     init_idx <= init_idx + 1'b1;
                     if (init_idx == 2'd2) init_done <= 1'b1;
                  end
                  OWN_HOST: begin
                     host_ack <= 1'b1;
                     if (txn_err) host_rdata <= 16'hFFFF;
                     else if (mdio_opcode == OP_RD) host_rdata <= cap;
                  end
`ifdef MDIO_PHY_MGR_LINK_POLL_EN
                  OWN_POLL: if (!txn_err) link_q <= cap[2];
`endif
                  default: ;
               endcase
            end
            default: state <= WAIT_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_phy_mgr.sv
// tb_mdio_phy_mgr: directed bench for mdio_phy_mgr with an MDIO driver model,
// an expected-transaction/ack scoreboard and a per-cycle compare process.
module tb_mdio_phy_mgr;
   localparam int RST_WAIT    = 100;
   localparam int POLL_PERIOD = 400;
   localparam int TIMEOUT     = 200;
   localparam int TXN         = 66;
   localparam logic [1:0] WR  = 2'b01;
   localparam logic [1:0] RD  = 2'b10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mdio_start;
   logic [1:0]  mdio_opcode;
   logic [4:0]  mdio_phy_addr, mdio_reg_addr;
   logic [15:0] mdio_wdata;
   logic        mdio_ready;
   logic [15:0] mdio_rdata;
   logic        mdio_rdata_en;
   logic        host_req, host_wr;
   logic [4:0]  host_reg;
   logic [15:0] host_wdata;
   logic        host_ack;
   logic [15:0] host_rdata;
   logic        init_done, link_up, err;

   always #5 clk = ~clk;

   mdio_phy_mgr #(.PHY_ADDR(5'd1), .RST_WAIT(RST_WAIT), .POLL_PERIOD(POLL_PERIOD),
                  .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .mdio_start(mdio_start), .mdio_opcode(mdio_opcode), .mdio_phy_addr(mdio_phy_addr),
      .mdio_reg_addr(mdio_reg_addr), .mdio_wdata(mdio_wdata), .mdio_ready(mdio_ready),
      .mdio_rdata(mdio_rdata), .mdio_rdata_en(mdio_rdata_en),
      .host_req(host_req), .host_wr(host_wr), .host_reg(host_reg), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .init_done(init_done), .link_up(link_up), .err(err));

   typedef struct { logic [1:0] op; logic [4:0] rg; logic [15:0] wd; bit poll; } txn_t;
   typedef struct { bit rd; logic [15:0] data; } ack_t;
   txn_t exp_q[$];
   ack_t ack_q[$];

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int start_cnt = 0, first_start_cyc = 0, poll_start_cyc = -1, last_poll_gap = 0;
   bit prev_start = 0, prev_ack = 0;
   bit drv_hang = 0, drv_no_rd = 0;
   logic [15:0] rd_val = 16'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_txn(input logic [1:0] op, input logic [4:0] rg, input logic [15:0] wd,
                           input bit poll);
      txn_t t;
      t.op = op; t.rg = rg; t.wd = wd; t.poll = poll;
      exp_q.push_back(t);
   endtask

   task automatic push_ack(input bit rd, input logic [15:0] data);
      ack_t a;
      a.rd = rd; a.data = data;
      ack_q.push_back(a);
   endtask

   task automatic push_init();
      push_txn(WR, 5'h00, 16'h1140, 0);
      push_txn(WR, 5'h04, 16'h01E1, 0);
      push_txn(WR, 5'h00, 16'h1340, 0);
   endtask

   function automatic logic outs_any();
      return |{mdio_start, mdio_opcode, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
               host_ack, host_rdata, init_done, link_up, err};
   endfunction

   function automatic logic sig_of(input int which);
      case (which)
         0:       return init_done;
         1:       return link_up;
         2:       return host_ack;
         3:       return mdio_ready;
         default: return logic'(start_cnt != 0);
      endcase
   endfunction

   task automatic wait_for(input int which, input logic val, input int max_cyc, input string name);
      bit seen = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (sig_of(which) === val) seen = 1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   // driver model: ready drops 2 cycles after start, read data strobed just before ready returns
   initial begin
      logic [1:0] op;
      mdio_ready = 1'b1; mdio_rdata_en = 1'b0; mdio_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (mdio_start === 1'b1 && !drv_hang) begin
            op = mdio_opcode;
            @(negedge clk);
            mdio_ready = 1'b0;
            repeat (TXN - 4) @(negedge clk);
            if (op == RD && !drv_no_rd) begin
               mdio_rdata = rd_val;
               mdio_rdata_en = 1'b1;
            end
            @(negedge clk);
            mdio_rdata_en = 1'b0;
            mdio_ready = 1'b1;
         end
      end
   end

   // scoreboard: every start must match the next expected transaction, every ack the next ack
   always @(negedge clk) begin
      txn_t e;
      ack_t a;
      if (reset_n) begin
         if (mdio_start) begin
            check("start_single_pulse", 32'(prev_start), 32'd0);
            if (start_cnt == 0) first_start_cyc = cyc;
            start_cnt++;
            if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("txn_opcode", 32'(mdio_opcode), 32'(e.op));
               check("txn_phy_addr", 32'(mdio_phy_addr), 32'd1);
               check("txn_reg", 32'(mdio_reg_addr), 32'(e.rg));
               if (e.op == WR) check("txn_wdata", 32'(mdio_wdata), 32'(e.wd));
               if (e.poll) begin
                  if (poll_start_cyc >= 0) last_poll_gap = cyc - poll_start_cyc;
                  poll_start_cyc = cyc;
               end
            end
         end
         if (host_ack) begin
            check("ack_single_pulse", 32'(prev_ack), 32'd0);
            if (ack_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
               a = ack_q.pop_front();
               if (a.rd) check("host_rdata", 32'(host_rdata), 32'(a.data));
            end
         end
      end
      prev_start = mdio_start;
      prev_ack   = host_ack;
   end

   initial begin
      int rel, t0, n;
      reset_n = 1'b0; host_req = 1'b0; host_wr = 1'b0; host_reg = 5'd0; host_wdata = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero", 32'(outs_any()), 32'd0);

      // init table after reset wait
      push_init();
      start_cnt = 0; rel = cyc; reset_n = 1'b1;
      wait_for(0, 1'b1, RST_WAIT + 4 * TXN + 50, "init_done_wait");
      check("init_first_start_delay", 32'((first_start_cyc - rel) >= RST_WAIT &&
                                          (first_start_cyc - rel) <= RST_WAIT + 5), 32'd1);
      check("init_start_count", 32'(start_cnt), 32'd3);
      check("init_err", 32'(err), 32'd0);
      check("init_link_down", 32'(link_up), 32'd0);

      // host read of reg 2
      push_txn(RD, 5'h02, 16'h0, 0); push_ack(1, 16'h4F51);
      rd_val = 16'h4F51; host_wr = 1'b0; host_reg = 5'h02; host_req = 1'b1; t0 = cyc;
      wait_for(2, 1'b1, TXN + 40, "host_read_ack");
      host_req = 1'b0;
      check("host_read_latency", 32'((cyc - t0) >= TXN && (cyc - t0) <= TXN + 6), 32'd1);
      check("host_read_data", 32'(host_rdata), 32'h4F51);
      @(negedge clk);
      check("host_ack_dropped", 32'(host_ack), 32'd0);

`ifdef MDIO_PHY_MGR_LINK_POLL_EN
      // polls: BMSR bit 2 set, then clear
      push_txn(RD, 5'h01, 16'h0, 1); rd_val = 16'h796D;
      wait_for(1, 1'b1, POLL_PERIOD + 2 * TXN + 50, "poll1_link_up");
      push_txn(RD, 5'h01, 16'h0, 1); rd_val = 16'h7969;
      wait_for(1, 1'b0, POLL_PERIOD + TXN + 50, "poll2_link_down");
      check("poll_spacing", 32'(last_poll_gap >= POLL_PERIOD + TXN - 4 &&
                                last_poll_gap <= POLL_PERIOD + TXN + 8), 32'd1);
      // host request lands in the cycle the poll timer expires: host first
      repeat (POLL_PERIOD) @(negedge clk);
      push_txn(WR, 5'h04, 16'h05E1, 0); push_ack(0, 16'h0);
      push_txn(RD, 5'h01, 16'h0, 1); rd_val = 16'h796D;
      host_wr = 1'b1; host_reg = 5'h04; host_wdata = 16'h05E1; host_req = 1'b1;
      wait_for(2, 1'b1, TXN + 40, "host_vs_poll_ack");
      host_req = 1'b0;
      wait_for(1, 1'b1, 2 * TXN + 40, "poll3_link_up");
      check("poll_queue_drained", 32'(exp_q.size()), 32'd0);
`else
      // without the poller: a host write, then no unsolicited traffic
      push_txn(WR, 5'h04, 16'h05E1, 0); push_ack(0, 16'h0);
      host_wr = 1'b1; host_reg = 5'h04; host_wdata = 16'h05E1; host_req = 1'b1;
      wait_for(2, 1'b1, TXN + 40, "host_write_ack");
      host_req = 1'b0;
      n = start_cnt;
      repeat (POLL_PERIOD + 150) @(negedge clk);
      check("no_poll_traffic", 32'(start_cnt), 32'(n));
      check("link_tied_low", 32'(link_up), 32'd0);
`endif

      // reset in WAIT_DONE aborts the host read; init restarts from entry 0
      push_txn(RD, 5'h02, 16'h0, 0); push_ack(1, 16'h1234);
      rd_val = 16'h1234; host_wr = 1'b0; host_reg = 5'h02; host_req = 1'b1;
      wait_for(3, 1'b0, 40, "abort_ready_drop");
      repeat (10) @(negedge clk);
      reset_n = 1'b0; host_req = 1'b0;
      @(negedge clk);
      check("abort_outputs_zero", 32'(outs_any()), 32'd0);
      ack_q.delete(); exp_q.delete();
      repeat (2) @(negedge clk);
      push_init();
      start_cnt = 0; rel = cyc; reset_n = 1'b1;
      wait_for(0, 1'b1, RST_WAIT + 4 * TXN + 50, "reinit_done_wait");
      check("reinit_first_start_delay", 32'((first_start_cyc - rel) >= RST_WAIT &&
                                            (first_start_cyc - rel) <= RST_WAIT + 5), 32'd1);
      check("reinit_queue_drained", 32'(exp_q.size()), 32'd0);
      check("reinit_err", 32'(err), 32'd0);

      // read that completes without a data strobe
      drv_no_rd = 1'b1;
      push_txn(RD, 5'h03, 16'h0, 0); push_ack(1, 16'hFFFF);
      host_reg = 5'h03; host_req = 1'b1;
      wait_for(2, 1'b1, TXN + 40, "nodata_ack");
      host_req = 1'b0;
      check("nodata_rdata", 32'(host_rdata), 32'hFFFF);
      check("nodata_err", 32'(err), 32'd1);
      drv_no_rd = 1'b0;

      // driver never responds: every init entry times out but init still completes
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("err_cleared_by_reset", 32'(err), 32'd0);
      drv_hang = 1'b1;
      push_init();
      start_cnt = 0; reset_n = 1'b1;
      wait_for(4, 1'b1, RST_WAIT + 20, "hang_first_start");
      repeat (TIMEOUT - 2) @(negedge clk);
      check("hang_err_before_timeout", 32'(err), 32'd0);
      repeat (4) @(negedge clk);
      check("hang_err_after_timeout", 32'(err), 32'd1);
      wait_for(0, 1'b1, 3 * TIMEOUT + 50, "hang_init_done");
      check("hang_start_count", 32'(start_cnt), 32'd3);
      check("hang_queue_drained", 32'(exp_q.size()), 32'd0);
      push_txn(RD, 5'h02, 16'h0, 0); push_ack(1, 16'hFFFF);
      host_reg = 5'h02; host_req = 1'b1;
      wait_for(2, 1'b1, TIMEOUT + 20, "hang_host_ack");
      host_req = 1'b0;
      check("hang_host_rdata", 32'(host_rdata), 32'hFFFF);
      check("hang_link_unchanged", 32'(link_up), 32'd0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mdio_phy_mgr.md
# mdio_phy_mgr

Sequencing controller for the MDIO master driver. After reset it runs a fixed PHY initialisation write table, then shares the single MDIO master between a host register-access port and a periodic link-status poller. The block runs in the MDC clock domain, the same domain as the driver, so no synchronisers are needed on the driver handshake. Outputs are `init_done`, a registered `link_up` and a sticky `err`.

## Interface
- `PHY_ADDR`, 5'd1 — PHY address driven on every transaction.
- `RST_WAIT`, 1000 — MDC cycles to wait after reset release before the first transaction.
- `POLL_PERIOD`, 50000 — MDC cycles between link polls, measured from the end of the previous poll.
- `TIMEOUT`, 200 — maximum MDC cycles for a transaction to complete.

Ports:
- `clk` in 1 — MDC-rate clock, same clock as the driver.
- `reset_n` in 1 — reset, synchronous, active-low.
- `mdio_start` out 1 — one-cycle start pulse to the driver.
- `mdio_opcode` out 2 — 2'b01 write, 2'b10 read; held stable for the whole transaction.
- `mdio_phy_addr` out 5 — always `PHY_ADDR`.
- `mdio_reg_addr` out 5 — register address.
- `mdio_wdata` out 16 — write data.
- `mdio_ready` in 1 — driver idle flag.
- `mdio_rdata` in 16 — driver read data.
- `mdio_rdata_en` in 1 — read-data-valid pulse from the driver.
- `host_req` in 1 — level request; hold until `host_ack`.
- `host_wr` in 1 — 1 = write, 0 = read.
- `host_reg` in 5 — host register address.
- `host_wdata` in 16 — host write data.
- `host_ack` out 1 — one-cycle completion pulse.
- `host_rdata` out 16 — host read data, valid with `host_ack`.
- `init_done` out 1 — init table finished.
- `link_up` out 1 — last polled BMSR bit 2.
- `err` out 1 — sticky timeout/protocol error flag.

## Operation
- Reset value of every output is 0. While reset is asserted the FSM is held in WAIT_RST and the table index is 0.
- FSM states: WAIT_RST, ARB, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH.
- WAIT_RST: count `RST_WAIT` cycles, then go to ARB.
- ARB: select the owner of the next transaction. INIT owns the master until all 3 table entries are done. After that, HOST has priority over POLL. POLL is selected only when the poll timer has expired. If nothing is selected, stay in ARB.
- Init table, all writes:
  - reg 0x00 = 16'h1140
  - reg 0x04 = 16'h01E1
  - reg 0x00 = 16'h1340
- ISSUE: drive opcode, reg and data; pulse `mdio_start`; go to WAIT_BUSY.
- WAIT_BUSY: wait for `mdio_ready` = 0.
- WAIT_DONE: wait for `mdio_ready` = 1. If `mdio_rdata_en` is seen during WAIT_DONE, capture `mdio_rdata`.
- FINISH: retire the transaction by owner, then return to ARB.
  - INIT: increment the index. After index 2 completes, set `init_done` = 1.
  - HOST: pulse `host_ack`. On a read, `host_rdata` = captured data.
  - POLL: reads reg 0x01; `link_up` = captured bit 2; restart the poll timer.
- Error cases; in each, set `err`, go to FINISH, and do not update `link_up` or `host_rdata`:
  - a read reaches `mdio_ready` rising without a prior `mdio_rdata_en`;
  - the `TIMEOUT` counter, started at ISSUE, expires.
- After an INIT error the entry is counted anyway, so the sequence never deadlocks. A HOST error still pulses `host_ack`, with `host_rdata` = 16'hFFFF.
- Host inputs are sampled only in ISSUE. Dropping `host_req` mid-transaction does not abort the transaction.
- `err` clears only on reset.

## Timing
- `mdio_start` is high for exactly one cycle, in the ISSUE → WAIT_BUSY transition cycle.
- The driver drops `mdio_ready` 2 cycles after start. A full transaction takes about 66 MDC cycles.
- `host_ack` comes 1 cycle after `mdio_ready` returns high.
- Host latency from ARB, with the master free: 1 (ISSUE) + 1 (WAIT_BUSY entry) + ~66 + 1 cycles.
- When a host request and a poll expiry are valid in the same ARB cycle, the host wins. The poll is served at the next ARB.
- The poll timer saturates at `POLL_PERIOD` and does not count while INIT is active.
- Asserting reset in the middle of a transaction aborts it immediately: all outputs go to 0 on the next edge. The driver, being reset separately, finishes or flushes on its own.

## Configuration
- Macro: `MDIO_PHY_MGR_LINK_POLL_EN`.
- Defined: the POLL owner and poll timer exist as described above.
- Undefined: the poll logic is removed, `link_up` is tied to 0, and ARB serves only INIT and then HOST.

## Test plan
- Reset, driver model ready: after `RST_WAIT` cycles, 3 writes occur in order (0x00/1140, 0x04/01E1, 0x00/1340) with `PHY_ADDR` = 1, then `init_done` = 1, `err` = 0.
- After init, host read of reg 0x02 with the model returning 16'h4F51: `host_ack` is a single pulse and `host_rdata` = 16'h4F51.
- Poll with BMSR = 16'h796D: `link_up` = 1. Next poll with BMSR = 16'h7969: `link_up` = 0. Consecutive `mdio_start` pulses for polls are `POLL_PERIOD` + transaction cycles apart.
- Host request asserted in the same cycle the poll timer expires: the host transaction is issued first, then the poll.
- Driver model never drops ready: after `TIMEOUT` cycles, `err` = 1, the init index advances, and the FSM returns to ARB.
- Reset asserted at WAIT_DONE: all outputs are 0 on the next cycle, and the init table restarts from entry 0 after `RST_WAIT`.
